// File: rtl/commit_reorder_unit.sv
// Commit reorder unit: gathers tagged, out-of-order branch results in a small reorder buffer
// and retires them in commit-ID order to the channel register file or the accumulator.
module commit_reorder_unit #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned N_BR      = 4,
    parameter int unsigned ID_W      = 9,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CH_ADDR_W = 4,
    parameter int unsigned SHIFT     = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        sample_tick,
    input  logic [DATA_W-1:0]           sample_in,
    input  logic                        resync,
    input  logic [N_BR-1:0]             in_valid,
    output logic [N_BR-1:0]             in_ready,
    input  logic [N_BR*ID_W-1:0]        in_id,
    input  logic [N_BR*2*DATA_W-1:0]    in_result,
    input  logic [N_BR*CH_ADDR_W-1:0]   in_dest,
    input  logic [N_BR-1:0]             in_to_acc,
    input  logic [N_BR-1:0]             in_acc_ovr,
    output logic                        ch_wr_en,
    output logic [CH_ADDR_W-1:0]        ch_wr_addr,
    output logic [DATA_W-1:0]           ch_wr_val,
    output logic                        acc_wr_en,
    output logic                        acc_add_en,
    output logic [2*DATA_W-1:0]         acc_wr_val,
    output logic [ID_W-1:0]             next_commit_id,
    output logic [$clog2(DEPTH):0]      rob_count,
    output logic                        dup_err
);

    localparam int unsigned SLOT_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = SLOT_W + 1;
    localparam int unsigned RES_W  = 2 * DATA_W;

    typedef struct packed {
        logic [RES_W-1:0]     result;
        logic [CH_ADDR_W-1:0] dest;
        logic                 to_acc;
        logic                 add;
    } entry_t;

    logic [DEPTH-1:0]     valid_q, valid_d;
    entry_t               entry_q [DEPTH];
    entry_t               entry_d [DEPTH];
    logic [ID_W-1:0]      ncid_q, ncid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dup_q, dup_d;
    logic                 ch_en_q, ch_en_d;
    logic [CH_ADDR_W-1:0] ch_addr_q, ch_addr_d;
    logic [DATA_W-1:0]    ch_val_q, ch_val_d;
    logic                 acc_en_q, acc_en_d;
    logic                 acc_add_q, acc_add_d;
    logic [RES_W-1:0]     acc_val_q, acc_val_d;

    logic                 live;
    logic [ID_W-1:0]      br_id   [N_BR];
    logic [ID_W-1:0]      br_off  [N_BR];
    logic [SLOT_W-1:0]    br_slot [N_BR];
    logic [N_BR-1:0]      br_win;
    logic                 dup_hit;
    logic [SLOT_W-1:0]    ret_slot;
    logic                 retire;
    entry_t               ret_entry;
    logic [CNT_W-1:0]     n_acc;

    logic signed [RES_W-1:0]  shifted;
    logic [RES_W-DATA_W:0]    top;
    logic [DATA_W-1:0]        sat_val;

    // Accept and retire share one qualifier; a tick or resync cycle does neither.
    assign live = enable && !sample_tick && !resync;

    always_comb begin
        br_win = '0;
        for (int i = 0; i < N_BR; i++) begin
            br_id[i]   = in_id[i*ID_W +: ID_W];
            br_off[i]  = br_id[i] - ncid_q;
            br_slot[i] = br_id[i][SLOT_W-1:0];
            br_win[i]  = br_off[i] < ID_W'(DEPTH);
        end
    end

    // Two in-window IDs sharing a slot must be the same ID, so any collision is a duplicate.
    always_comb begin
        in_ready = '0;
        dup_hit  = 1'b0;
        for (int i = 0; i < N_BR; i++) begin
            if (live && in_valid[i] && br_win[i]) begin
                if (valid_q[br_slot[i]]) begin
                    dup_hit = 1'b1;
                end else begin
                    in_ready[i] = 1'b1;
                    for (int j = 0; j < i; j++) begin
                        if (in_ready[j] && (br_id[j] == br_id[i])) begin
                            in_ready[i] = 1'b0;
                            dup_hit     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ret_slot  = ncid_q[SLOT_W-1:0];
        retire    = live && valid_q[ret_slot];
        ret_entry = entry_q[ret_slot];
    end

    always_comb begin
        shifted = $signed(ret_entry.result) >>> SHIFT;
        top     = shifted[RES_W-1:DATA_W-1];
        if (&top || ~|top) begin
            sat_val = shifted[DATA_W-1:0];
        end else if (shifted[RES_W-1]) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        valid_d   = valid_q;
        entry_d   = entry_q;
        ncid_d    = ncid_q;
        dup_d     = dup_q | dup_hit;
        ch_en_d   = 1'b0;
        ch_addr_d = ch_addr_q;
        ch_val_d  = ch_val_q;
        acc_en_d  = 1'b0;
        acc_add_d = acc_add_q;
        acc_val_d = acc_val_q;
        n_acc     = '0;

        if (retire) begin
            valid_d[ret_slot] = 1'b0;
            ncid_d            = ncid_q + 1'b1;
            if (ret_entry.to_acc) begin
                acc_en_d  = 1'b1;
                acc_add_d = ret_entry.add;
                acc_val_d = ret_entry.result;
            end else begin
                ch_en_d   = 1'b1;
                ch_addr_d = ret_entry.dest;
                ch_val_d  = sat_val;
            end
        end

        for (int i = 0; i < N_BR; i++) begin
            if (in_ready[i]) begin
                valid_d[br_slot[i]]        = 1'b1;
                entry_d[br_slot[i]].result = in_result[i*RES_W +: RES_W];
                entry_d[br_slot[i]].dest   = in_dest[i*CH_ADDR_W +: CH_ADDR_W];
                entry_d[br_slot[i]].to_acc = in_to_acc[i];
                entry_d[br_slot[i]].add    = ~in_acc_ovr[i];
                n_acc                      = n_acc + 1'b1;
            end
        end

        cnt_d = cnt_q + n_acc - CNT_W'(retire);

        if (enable && resync) begin
            valid_d = '0;
            ncid_d  = '0;
            cnt_d   = '0;
        end else if (enable && sample_tick) begin
            ch_en_d   = 1'b1;
            ch_addr_d = '0;
            ch_val_d  = sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            ncid_q    <= '0;
            cnt_q     <= '0;
            dup_q     <= 1'b0;
            ch_en_q   <= 1'b0;
            ch_addr_q <= '0;
            ch_val_q  <= '0;
            acc_en_q  <= 1'b0;
            acc_add_q <= 1'b0;
            acc_val_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ncid_q    <= ncid_d;
            cnt_q     <= cnt_d;
            dup_q     <= dup_d;
            ch_en_q   <= ch_en_d;
            ch_addr_q <= ch_addr_d;
            ch_val_q  <= ch_val_d;
            acc_en_q  <= acc_en_d;
            acc_add_q <= acc_add_d;
            acc_val_q <= acc_val_d;
        end
    end

    // Payload needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign ch_wr_en       = ch_en_q;
    assign ch_wr_addr     = ch_addr_q;
    assign ch_wr_val      = ch_val_q;
    assign acc_wr_en      = acc_en_q;
    assign acc_add_en     = acc_add_q;
    assign acc_wr_val     = acc_val_q;
    assign next_commit_id = ncid_q;
    assign rob_count      = cnt_q;
    assign dup_err        = dup_q;

endmodule

// File: tb/tb_commit_reorder_unit.sv
// Bench for commit_reorder_unit: directed scenarios plus random traffic, all checked against
// an ID-indexed reference model of the commit rules.
module tb_commit_reorder_unit;

    localparam int DATA_W    = 16;
    localparam int N_BR      = 4;
    localparam int ID_W      = 9;
    localparam int DEPTH     = 8;
    localparam int CH_ADDR_W = 4;
    localparam int SHIFT     = 0;
    localparam int RES_W     = 2 * DATA_W;
    localparam int ID_SPACE  = 1 << ID_W;
    localparam longint MAXV  = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint MINV  = -(longint'(1) << (DATA_W - 1));

    logic                       clk = 1'b0;
    logic                       reset, enable, sample_tick, resync;
    logic [DATA_W-1:0]          sample_in;
    logic [N_BR-1:0]            in_valid, in_ready, in_to_acc, in_acc_ovr;
    logic [N_BR*ID_W-1:0]       in_id;
    logic [N_BR*RES_W-1:0]      in_result;
    logic [N_BR*CH_ADDR_W-1:0]  in_dest;
    logic                       ch_wr_en, acc_wr_en, acc_add_en, dup_err;
    logic [CH_ADDR_W-1:0]       ch_wr_addr;
    logic [DATA_W-1:0]          ch_wr_val;
    logic [RES_W-1:0]           acc_wr_val;
    logic [ID_W-1:0]            next_commit_id;
    logic [$clog2(DEPTH):0]     rob_count;

    commit_reorder_unit #(
        .DATA_W(DATA_W), .N_BR(N_BR), .ID_W(ID_W), .DEPTH(DEPTH),
        .CH_ADDR_W(CH_ADDR_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .sample_in(sample_in), .resync(resync), .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_result(in_result), .in_dest(in_dest), .in_to_acc(in_to_acc),
        .in_acc_ovr(in_acc_ovr), .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr),
        .ch_wr_val(ch_wr_val), .acc_wr_en(acc_wr_en), .acc_add_en(acc_add_en),
        .acc_wr_val(acc_wr_val), .next_commit_id(next_commit_id), .rob_count(rob_count),
        .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-branch offered transaction
    logic                 b_valid [N_BR];
    logic [ID_W-1:0]      b_id    [N_BR];
    logic [RES_W-1:0]     b_res   [N_BR];
    logic [CH_ADDR_W-1:0] b_dest  [N_BR];
    logic                 b_acc   [N_BR];
    logic                 b_ovr   [N_BR];

    // Reference model: pending results keyed directly by commit ID
    bit                   m_present [ID_SPACE];
    logic [RES_W-1:0]     m_res     [ID_SPACE];
    logic [CH_ADDR_W-1:0] m_dest    [ID_SPACE];
    bit                   m_acc     [ID_SPACE];
    bit                   m_ovr     [ID_SPACE];
    int                   m_next, m_count;
    bit                   m_dup, m_dup_hit;
    logic [N_BR-1:0]      exp_ready, last_ready;
    bit                   e_ch_en, e_acc_en, e_acc_add;
    logic [CH_ADDR_W-1:0] e_ch_addr;
    logic [DATA_W-1:0]    e_ch_val;
    logic [RES_W-1:0]     e_acc_val;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] sat_ref(input logic [RES_W-1:0] r);
        longint v;
        v = longint'($signed(r));
        v = v >>> SHIFT;
        if (v > MAXV) v = MAXV;
        else if (v < MINV) v = MINV;
        return v[DATA_W-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ID_SPACE; k++) m_present[k] = 0;
        m_next = 0; m_count = 0; m_dup = 0;
        e_ch_en = 0; e_acc_en = 0; e_acc_add = 0;
        e_ch_addr = '0; e_ch_val = '0; e_acc_val = '0;
    endtask

    task automatic model_eval();
        bit live, busy;
        int id, off;
        live      = enable && !sample_tick && !resync;
        exp_ready = '0;
        m_dup_hit = 0;
        for (int i = 0; i < N_BR; i++) begin
            id  = int'(b_id[i]);
            off = (id - m_next + ID_SPACE) % ID_SPACE;
            if (live && b_valid[i] && off < DEPTH) begin
                busy = 0;
                for (int k = 0; k < ID_SPACE; k++)
                    if (m_present[k] && (k % DEPTH) == (id % DEPTH)) busy = 1;
                for (int j = 0; j < i; j++)
                    if (exp_ready[j] && b_id[j] == b_id[i]) busy = 1;
                if (busy) m_dup_hit = 1;
                else exp_ready[i] = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        int id;
        e_ch_en  = 0;
        e_acc_en = 0;
        if (enable && !sample_tick && !resync && m_present[m_next]) begin
            m_present[m_next] = 0;
            if (m_acc[m_next]) begin
                e_acc_en  = 1;
                e_acc_add = !m_ovr[m_next];
                e_acc_val = m_res[m_next];
            end else begin
                e_ch_en   = 1;
                e_ch_addr = m_dest[m_next];
                e_ch_val  = sat_ref(m_res[m_next]);
            end
            m_next = (m_next + 1) % ID_SPACE;
            m_count--;
        end
        for (int i = 0; i < N_BR; i++) begin
            if (exp_ready[i]) begin
                id = int'(b_id[i]);
                m_present[id] = 1;
                m_res[id]  = b_res[i];
                m_dest[id] = b_dest[i];
                m_acc[id]  = b_acc[i];
                m_ovr[id]  = b_ovr[i];
                m_count++;
            end
        end
        if (m_dup_hit) m_dup = 1;
        if (enable && resync) begin
            for (int k = 0; k < ID_SPACE; k++) m_present[k] = 0;
            m_next = 0; m_count = 0;
        end else if (enable && sample_tick) begin
            e_ch_en = 1; e_ch_addr = '0; e_ch_val = sample_in;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_BR; i++) begin
            in_valid[i]                        = b_valid[i];
            in_id[i*ID_W +: ID_W]              = b_id[i];
            in_result[i*RES_W +: RES_W]        = b_res[i];
            in_dest[i*CH_ADDR_W +: CH_ADDR_W]  = b_dest[i];
            in_to_acc[i]                       = b_acc[i];
            in_acc_ovr[i]                      = b_ovr[i];
        end
    endtask

    task automatic check_outputs();
        check_eq("ch_wr_en", 64'(ch_wr_en), 64'(e_ch_en));
        check_eq("acc_wr_en", 64'(acc_wr_en), 64'(e_acc_en));
        if (e_ch_en) begin
            check_eq("ch_wr_addr", 64'(ch_wr_addr), 64'(e_ch_addr));
            check_eq("ch_wr_val", 64'(ch_wr_val), 64'(e_ch_val));
        end
        if (e_acc_en) begin
            check_eq("acc_add_en", 64'(acc_add_en), 64'(e_acc_add));
            check_eq("acc_wr_val", 64'(acc_wr_val), 64'(e_acc_val));
        end
        check_eq("next_commit_id", 64'(next_commit_id), 64'(m_next));
        check_eq("rob_count", 64'(rob_count), 64'(m_count));
        check_eq("dup_err", 64'(dup_err), 64'(m_dup));
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic step();
        drive();
        #1;
        model_eval();
        last_ready = in_ready;
        check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        model_commit();
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < N_BR; i++) if (exp_ready[i]) b_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic set_br(input int i, input int id, input logic [RES_W-1:0] res,
                          input int dest, input bit acc, input bit ovr);
        b_valid[i] = 1'b1;
        b_id[i]    = ID_W'(id % ID_SPACE);
        b_res[i]   = res;
        b_dest[i]  = CH_ADDR_W'(dest);
        b_acc[i]   = acc;
        b_ovr[i]   = ovr;
    endtask

    task automatic clear_br();
        for (int i = 0; i < N_BR; i++) begin
            b_valid[i] = 1'b0; b_id[i] = '0; b_res[i] = '0;
            b_dest[i] = '0; b_acc[i] = 1'b0; b_ovr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; sample_tick = 1'b0; resync = 1'b0; sample_in = '0;
        clear_br();
        drive();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [RES_W-1:0] rand_result();
        int sel, mag;
        sel = $urandom_range(0, 3);
        if (sel == 0) return RES_W'($urandom());
        if (sel == 1) return RES_W'($urandom_range(32760, 32775));
        mag = $urandom_range(1, 32770);
        if (sel == 2) return RES_W'(-mag);
        return RES_W'($urandom_range(0, 32767));
    endfunction

    initial begin
        int next_issue;
        bit b_loaded [N_BR];
        int b_wait   [N_BR];

        @(negedge clk);
        do_reset();
        check_eq("rst_ch_wr_en", 64'(ch_wr_en), 64'(0));
        check_eq("rst_ch_wr_addr", 64'(ch_wr_addr), 64'(0));
        check_eq("rst_ch_wr_val", 64'(ch_wr_val), 64'(0));
        check_eq("rst_acc_wr_en", 64'(acc_wr_en), 64'(0));
        check_eq("rst_acc_add_en", 64'(acc_add_en), 64'(0));
        check_eq("rst_acc_wr_val", 64'(acc_wr_val), 64'(0));
        check_eq("rst_next_id", 64'(next_commit_id), 64'(0));
        check_eq("rst_rob_count", 64'(rob_count), 64'(0));
        check_eq("rst_dup_err", 64'(dup_err), 64'(0));
        enable = 1'b1;

        // In-order single branch
        for (int k = 0; k < 3; k++) begin
            set_br(0, k, 32'h0000_1234, 3, 0, 0);
            step();
        end
        idle(2);
        check_eq("inorder_next_id", 64'(next_commit_id), 64'(3));

        // Out-of-order arrival: ID 4 first, ID 3 two cycles later
        set_br(1, 4, 32'h0000_0044, 2, 0, 0);
        step();
        idle(1);
        set_br(0, 3, 32'h0000_0033, 1, 0, 0);
        step();
        check_eq("ooo_peak", 64'(rob_count), 64'(2));
        step();
        check_eq("ooo_first", 64'(ch_wr_addr), 64'(1));
        step();
        check_eq("ooo_second", 64'(ch_wr_addr), 64'(2));

        // Saturation and accumulator
        set_br(0, m_next, 32'h0001_2345, 5, 0, 0);
        set_br(1, m_next + 1, 32'hFFFF_0000, 6, 0, 0);
        set_br(2, m_next + 2, 32'h00AB_CDEF, 0, 1, 0);
        step();
        step();
        check_eq("sat_hi", 64'(ch_wr_val), 64'(16'h7FFF));
        step();
        check_eq("sat_lo", 64'(ch_wr_val), 64'(16'h8000));
        step();
        check_eq("mac_en", 64'(acc_wr_en), 64'(1));
        check_eq("mac_add", 64'(acc_add_en), 64'(1));
        check_eq("mac_val", 64'(acc_wr_val), 64'(32'h00AB_CDEF));

        // Sample tick while an entry is pending and a branch is offering
        set_br(0, m_next, 32'h0000_0077, 7, 0, 0);
        step();
        sample_tick = 1'b1;
        sample_in   = 16'h5A5A;
        set_br(1, m_next + 1, 32'h0000_0099, 9, 0, 0);
        step();
        check_eq("tick_ready", 64'(last_ready), 64'(0));
        check_eq("tick_addr", 64'(ch_wr_addr), 64'(0));
        check_eq("tick_val", 64'(ch_wr_val), 64'(16'h5A5A));
        sample_tick = 1'b0;
        step();
        check_eq("post_tick_addr", 64'(ch_wr_addr), 64'(7));
        idle(2);

        // Random traffic; IDs issued in order, presented after random per-branch delays
        next_issue = m_next;
        for (int i = 0; i < N_BR; i++) begin
            b_loaded[i] = 0; b_wait[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            enable      = ($urandom_range(0, 19) != 0);
            sample_tick = ($urandom_range(0, 9) == 0);
            resync      = ($urandom_range(0, 199) == 0);
            sample_in   = DATA_W'($urandom());
            for (int i = 0; i < N_BR; i++) begin
                if (!b_loaded[i] && $urandom_range(0, 1) == 1) begin
                    set_br(i, next_issue, rand_result(), $urandom_range(0, 15),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                    next_issue  = (next_issue + 1) % ID_SPACE;
                    b_loaded[i] = 1;
                    b_wait[i]   = $urandom_range(0, 4);
                end
                b_valid[i] = b_loaded[i] && (b_wait[i] == 0);
                if (b_wait[i] > 0) b_wait[i]--;
            end
            step();
            for (int i = 0; i < N_BR; i++) if (exp_ready[i]) b_loaded[i] = 0;
            if (enable && resync) begin
                for (int i = 0; i < N_BR; i++) begin
                    b_loaded[i] = 0; b_valid[i] = 1'b0;
                end
                next_issue = 0;
            end
        end

        // Resync, then stream IDs 0..509 to park next_commit_id at 510
        clear_br();
        enable = 1'b1; sample_tick = 1'b0; resync = 1'b1;
        step();
        resync = 1'b0;
        for (int k = 0; k < 510; k++) begin
            set_br(0, k, rand_result(), $urandom_range(0, 15), $urandom_range(0, 1) == 1, 0);
            step();
        end
        idle(1);
        check_eq("ff_next_id", 64'(next_commit_id), 64'(510));

        // Window wrap with an out-of-window ID held on branch 3
        set_br(0, 510, 32'h0000_0510, 1, 0, 0);
        set_br(1, 511, 32'h0000_0511, 2, 0, 0);
        set_br(2, 0, 32'h0000_0000, 3, 0, 0);
        set_br(3, 10, 32'h0000_0010, 4, 0, 0);
        step();
        set_br(2, 1, 32'h0000_0001, 5, 0, 0);
        step();
        idle(4);
        check_eq("wrap_next_id", 64'(next_commit_id), 64'(2));
        check_eq("wrap_held", 64'(last_ready[3]), 64'(0));
        check_eq("wrap_no_dup", 64'(dup_err), 64'(0));
        b_valid[3] = 1'b0;
        idle(1);

        // Duplicate ID on two branches, then resync
        set_br(0, 5, 32'h0000_0055, 1, 0, 0);
        set_br(1, 5, 32'h0000_0066, 2, 0, 0);
        step();
        b_valid[1] = 1'b0;
        check_eq("dup_ready", 64'(last_ready), 64'(4'b0001));
        check_eq("dup_set", 64'(dup_err), 64'(1));
        resync = 1'b1;
        step();
        resync = 1'b0;
        check_eq("resync_count", 64'(rob_count), 64'(0));
        check_eq("resync_next_id", 64'(next_commit_id), 64'(0));
        check_eq("resync_dup", 64'(dup_err), 64'(1));
        idle(2);
        check_eq("dup_sticky", 64'(dup_err), 64'(1));

        do_reset();
        check_eq("final_dup", 64'(dup_err), 64'(0));
        check_eq("final_count", 64'(rob_count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
